// File: rtl/sd_reg_host_bridge.sv
// CPU valid/ready to SD host register-set bridge with setup/strobe timing.
// Optional write read-back verification is enabled by defining WR_VERIFY_EN.
module sd_reg_host_bridge #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 8'hFC,
    parameter int                RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        req,
    output logic              wnr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] reg_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RDWAIT,
        RESP
    } state_t;

    state_t     state;
    logic       wr_q;
    logic       vfy;
    logic [1:0] cnt;
    logic       bad_addr;

    assign bad_addr = (host_addr[1:0] != 2'b00) || (host_addr > MAX_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            host_ready <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req        <= 2'b00;
            wnr        <= 1'b0;
            address    <= '0;
            data_in    <= '0;
            wr_q       <= 1'b0;
            vfy        <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (host_valid && host_ready) begin
                        host_ready <= 1'b0;
                        wr_q       <= host_wr;
                        vfy        <= 1'b0;
                        if (bad_addr) begin
                            // No register-set activity on a rejected address
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state   <= SETUP;
                            req     <= 2'b11;
                            wnr     <= 1'b0;
                            address <= host_addr;
                            data_in <= host_wdata;
                        end
                    end else begin
                        host_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= STROBE;
                    wnr   <= wr_q & ~vfy;
                end
                STROBE: begin
                    wnr <= 1'b0;
                    if (wr_q && !vfy) begin
`ifdef WR_VERIFY_EN
                        state <= SETUP;
                        vfy   <= 1'b1;
`else
                        state      <= RESP;
                        req        <= 2'b00;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
`endif
                    end else begin
                        state <= RDWAIT;
                        cnt   <= 2'(RD_LAT - 1);
                    end
                end
                RDWAIT: begin
                    if (cnt == 2'd0) begin
                        state      <= RESP;
                        req        <= 2'b00;
                        resp_valid <= 1'b1;
                        resp_rdata <= reg_rdata;
                        resp_err   <= vfy && (reg_rdata != data_in);
                        vfy        <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    host_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_reg_host_bridge.sv
// Directed bench for sd_reg_host_bridge with a 64-word register-set model.
// Expectations adapt when WR_VERIFY_EN is defined.
module tb_sd_reg_host_bridge;

    localparam int RD_LAT = 1;
`ifdef WR_VERIFY_EN
    localparam int WLAT = 5 + RD_LAT;
    localparam logic VERR = 1'b1;
`else
    localparam int WLAT = 3;
    localparam logic VERR = 1'b0;
`endif
    localparam int RLAT = 3 + RD_LAT;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        host_valid;
    logic        host_valid2;
    logic        host_wr;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;

    logic        host_ready;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  req;
    logic        wnr;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] reg_rdata;

    logic        host_ready2;
    logic        resp_valid2;
    logic        resp_err2;
    logic [31:0] resp_rdata2;
    logic [1:0]  req2;
    logic        wnr2;
    logic [7:0]  address2;
    logic [31:0] data_in2;
    logic [31:0] reg_rdata2;

    logic        corrupt;
    logic [31:0] mem [64];
    logic [31:0] exp_d [64];

    int checks = 0;
    int failures = 0;
    int wnr_cnt;
    int bad_wnr;
    int ready_hi;
    int lat;
    int rv;

    sd_reg_host_bridge #(.RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .req        (req),
        .wnr        (wnr),
        .address    (address),
        .data_in    (data_in),
        .reg_rdata  (reg_rdata)
    );

    sd_reg_host_bridge #(.MAX_ADDR(8'hF0), .RD_LAT(RD_LAT)) dut_lim (
        .clk        (clk),
        .reset      (reset),
        .host_valid (host_valid2),
        .host_ready (host_ready2),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .resp_valid (resp_valid2),
        .resp_err   (resp_err2),
        .resp_rdata (resp_rdata2),
        .req        (req2),
        .wnr        (wnr2),
        .address    (address2),
        .data_in    (data_in2),
        .reg_rdata  (reg_rdata2)
    );

    // Register-set model: write on strobe, registered read (latency 1)
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]    <= 32'h12345678;
            reg_rdata <= 32'h0;
        end else begin
            if (req == 2'b11 && wnr) mem[address[7:2]] <= data_in;
            reg_rdata <= mem[address[7:2]] ^ {31'b0, corrupt};
        end
    end

    assign reg_rdata2 = 32'h0;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic start(input logic wr, input logic [7:0] a,
                         input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!host_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) chk("ready_timeout", {31'b0, host_ready}, 32'd1);
        wnr_cnt = 0;
        bad_wnr = 0;
        host_valid = 1'b1;
        host_wr    = wr;
        host_addr  = a;
        host_wdata = d;
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        host_wr    = ~wr;
        host_addr  = 8'h55;
        host_wdata = 32'hFFFF_FFFF;
    endtask

    task automatic wait_resp(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
            if (wnr) wnr_cnt++;
            if (wnr && req != 2'b11) bad_wnr++;
            if (host_ready) ready_hi++;
        end while (!resp_valid && l < 30);
        if (!resp_valid) l = -1;
    endtask

    initial begin
        reset       = 1'b0;
        corrupt     = 1'b0;
        host_valid  = 1'b1;
        host_valid2 = 1'b0;
        host_wr     = 1'b1;
        host_addr   = 8'h04;
        host_wdata  = 32'hCAFE_F00D;
        ready_hi    = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, host_ready}, 32'd0);
        chk("rst_req", {30'b0, req}, 32'd0);
        chk("rst_wnr", {31'b0, wnr}, 32'd0);
        chk("rst_addr", {24'b0, address}, 32'd0);
        chk("rst_data", data_in, 32'd0);
        chk("rst_resp", {31'b0, resp_valid}, 32'd0);
        reset      = 1'b1;
        host_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'b0, host_ready}, 32'd1);

        // Directed write, cycle by cycle
        start(1'b1, 8'h04, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_c1_req", {30'b0, req}, 32'd3);
        chk("wr_c1_wnr", {31'b0, wnr}, 32'd0);
        chk("wr_c1_addr", {24'b0, address}, 32'h04);
        chk("wr_c1_data", data_in, 32'hDEADBEEF);
        chk("wr_c1_ready", {31'b0, host_ready}, 32'd0);
        @(negedge clk);
        chk("wr_c2_req", {30'b0, req}, 32'd3);
        chk("wr_c2_wnr", {31'b0, wnr}, 32'd1);
        chk("wr_c2_addr", {24'b0, address}, 32'h04);
        chk("wr_c2_data", data_in, 32'hDEADBEEF);
        wait_resp(lat);
        chk("wr_lat", lat + 2, WLAT);
        chk("wr_err", {31'b0, resp_err}, 32'd0);
`ifdef WR_VERIFY_EN
        chk("wr_rdata", resp_rdata, 32'hDEADBEEF);
`else
        chk("wr_rdata", resp_rdata, 32'd0);
`endif
        chk("wr_resp_req", {30'b0, req}, 32'd0);
        chk("wr_extra_wnr", wnr_cnt, 32'd0);
        chk("wr_mem", mem[1], 32'hDEADBEEF);

        // Read of a preloaded register
        start(1'b0, 8'h10, 32'h0);
        wait_resp(lat);
        chk("rd_lat", lat, RLAT);
        chk("rd_rdata", resp_rdata, 32'h12345678);
        chk("rd_err", {31'b0, resp_err}, 32'd0);
        chk("rd_wnr", wnr_cnt, 32'd0);

        // Misaligned address
        start(1'b1, 8'h06, 32'h1111_2222);
        wait_resp(lat);
        chk("mis_lat", lat, 32'd1);
        chk("mis_err", {31'b0, resp_err}, 32'd1);
        chk("mis_req", {30'b0, req}, 32'd0);
        chk("mis_rdata", resp_rdata, 32'd0);
        chk("mis_wnr", wnr_cnt, 32'd0);

        // Above MAX_ADDR on the limited instance
        @(negedge clk);
        host_valid2 = 1'b1;
        host_wr     = 1'b1;
        host_addr   = 8'hF4;
        host_wdata  = 32'h3333_4444;
        @(posedge clk);
        #1;
        host_valid2 = 1'b0;
        @(negedge clk);
        chk("max_valid", {31'b0, resp_valid2}, 32'd1);
        chk("max_err", {31'b0, resp_err2}, 32'd1);
        chk("max_req", {30'b0, req2}, 32'd0);
        chk("max_wnr", {31'b0, wnr2}, 32'd0);

        // Back-to-back sweep: 64 writes then 64 reads
        ready_hi = 0;
        for (int i = 0; i < 64; i++) begin
            exp_d[i] = $urandom;
            start(1'b1, 8'(i * 4), exp_d[i]);
            wait_resp(lat);
            if (lat != WLAT || resp_err || wnr_cnt != 1 || bad_wnr != 0)
                chk("sweep_wr", {lat[7:0], 7'b0, resp_err,
                    wnr_cnt[7:0], bad_wnr[7:0]},
                    {WLAT[7:0], 8'd0, 8'd1, 8'd0});
        end
        for (int i = 0; i < 64; i++) begin
            start(1'b0, 8'(i * 4), 32'h0);
            wait_resp(lat);
            chk("sweep_rd", resp_rdata, exp_d[i]);
            if (lat != RLAT || resp_err || wnr_cnt != 0)
                chk("sweep_rd_ctl", {lat[7:0], 7'b0, resp_err, wnr_cnt[15:0]},
                    {RLAT[7:0], 24'd0});
        end
        chk("sweep_ready_low", ready_hi, 32'd0);

        // Asynchronous reset while waiting for read data
        start(1'b0, 8'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rdwait_req", {30'b0, req}, 32'd3);
        #1 reset = 1'b0;
        #1;
        chk("arst_req", {30'b0, req}, 32'd0);
        chk("arst_addr", {24'b0, address}, 32'd0);
        chk("arst_rdata", resp_rdata, 32'd0);
        chk("arst_ready", {31'b0, host_ready}, 32'd0);
        chk("arst_valid", {31'b0, resp_valid}, 32'd0);
        rv = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (resp_valid) rv++;
        chk("arst_rel_ready", {31'b0, host_ready}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        chk("arst_no_resp", rv, 32'd0);

        // Register model corrupting bit 0 on read-back
        corrupt = 1'b1;
        start(1'b1, 8'h20, 32'h0000_0055);
        wait_resp(lat);
        chk("vfy_lat", lat, WLAT);
        chk("vfy_err", {31'b0, resp_err}, {31'b0, VERR});
`ifdef WR_VERIFY_EN
        chk("vfy_rdata", resp_rdata, 32'h0000_0054);
`else
        chk("vfy_rdata", resp_rdata, 32'h0);
`endif
        corrupt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
